pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_if.sv | 36 +++
 rtl/pipe_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Hazard/branch/memory status from the pipeline stages and the stage control
// enables returned by pipe_ctrl.
interface pipe_ctrl_if;
  logic       ex_memread_i;
  logic [4:0] ex_rd_i;
  logic [4:0] id_rs1_i;
  logic [4:0] id_rs2_i;
  logic       id_use_rs2_i;
  logic       id_branch_taken_i;
  logic       mem_req_i;
  logic       mem_ack_i;
  logic       pc_write_o;
  logic       ifid_write_o;
  logic       ifid_flush_o;
  logic       idex_bubble_o;
  logic       pipe_stall_o;
  logic       err_o;
  logic [15:0] stall_cnt_o;
  logic [15:0] flush_cnt_o;

  // Controller side
  modport slave (
    input  ex_memread_i, ex_rd_i, id_rs1_i, id_rs2_i, id_use_rs2_i,
    input  id_branch_taken_i, mem_req_i, mem_ack_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_stall_o,
    output err_o, stall_cnt_o, flush_cnt_o
  );

  // Pipeline side
  modport master (
    output ex_memread_i, ex_rd_i, id_rs1_i, id_rs2_i, id_use_rs2_i,
    output id_branch_taken_i, mem_req_i, mem_ack_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_stall_o,
    input  err_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use interlock, taken-branch flush, data
// memory miss stall with timeout abort, and saturating stall/flush counters.
module pipe_ctrl #(
  parameter int unsigned TIMEOUT = 256
) (
  input logic        clk_i,
  input logic        rst_i,
  pipe_ctrl_if.slave bus
);

  localparam logic [15:0] WaitLast = 16'(TIMEOUT - 1);
  localparam logic [15:0] CntMax   = 16'hFFFF;

  typedef enum logic [0:0] {StRun, StMemWait} state_e;

  state_e      state_q, state_d;
  logic [15:0] wait_q, wait_d;
  logic        err_q, err_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic hazard, memstall;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, pipe_stall;

  // Load-use: the EX load writes a register the ID instruction actually reads.
  assign hazard = bus.ex_memread_i && (bus.ex_rd_i != 5'd0) &&
                  ((bus.ex_rd_i == bus.id_rs1_i) ||
                   (bus.id_use_rs2_i && (bus.ex_rd_i == bus.id_rs2_i)));

  assign memstall = ((state_q == StRun) && bus.mem_req_i && !bus.mem_ack_i) ||
                    ((state_q == StMemWait) && !bus.mem_ack_i);

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_stall  = 1'b0;
    if (!rst_i) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (memstall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_stall = 1'b1;
    end else if (hazard) begin
      // A taken branch seen alongside a hazard is picked up again next cycle.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (bus.id_branch_taken_i) begin
      ifid_flush = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    unique case (state_q)
      StRun: begin
        if (bus.mem_req_i && !bus.mem_ack_i) begin
          state_d = StMemWait;
          wait_d  = 16'd0;
        end
      end
      StMemWait: begin
        if (bus.mem_ack_i) begin
          state_d = StRun;
        end else if (wait_q == WaitLast) begin
          err_d   = 1'b1;
          state_d = StRun;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (ifid_flush && (flush_cnt_q != CntMax)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= StRun;
      wait_q      <= 16'd0;
      err_q       <= 1'b0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.pc_write_o    = pc_write;
  assign bus.ifid_write_o  = ifid_write;
  assign bus.ifid_flush_o  = ifid_flush;
  assign bus.idex_bubble_o = idex_bubble;
  assign bus.pipe_stall_o  = pipe_stall;
  assign bus.err_o         = err_q;
  assign bus.stall_cnt_o   = stall_cnt_q;
  assign bus.flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios plus random traffic,
// checked against a cycle-level behavioural model.
module tb_pipe_ctrl;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.TIMEOUT(TO)) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic        pcw;
    logic        ifw;
    logic        fl;
    logic        bub;
    logic        stl;
    logic        err;
    logic [15:0] sc;
    logic [15:0] fc;
  } obs_t;

  typedef struct {
    obs_t  v;
    string name;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Model state: whether a miss is outstanding and for how many wait cycles.
  bit m_waiting = 0;
  int m_waited  = 0;
  bit m_err     = 0;
  int m_sc      = 0;
  int m_fc      = 0;

  task automatic drive(input bit rst, input bit mr, input int rd, input int rs1, input int rs2,
                       input bit use2, input bit br, input bit req, input bit ack,
                       input string name);
    exp_t e;
    bit   haz, ms;
    @(posedge clk);
    #1;
    rst_n                 = rst;
    bus.ex_memread_i      = mr;
    bus.ex_rd_i           = 5'(rd);
    bus.id_rs1_i          = 5'(rs1);
    bus.id_rs2_i          = 5'(rs2);
    bus.id_use_rs2_i      = use2;
    bus.id_branch_taken_i = br;
    bus.mem_req_i         = req;
    bus.mem_ack_i         = ack;

    haz = mr && (rd != 0) && ((rd == rs1) || (use2 && (rd == rs2)));
    ms  = m_waiting ? !ack : (req && !ack);
    e.name = name;
    e.v = '0;
    if (!rst) begin
      e.v.fl  = 1'b1;
      e.v.bub = 1'b1;
    end else if (ms) begin
      e.v.stl = 1'b1;
    end else if (haz) begin
      e.v.bub = 1'b1;
    end else begin
      e.v.pcw = 1'b1;
      e.v.ifw = 1'b1;
      e.v.fl  = br;
    end
    e.v.err = m_err;
    e.v.sc  = 16'(m_sc);
    e.v.fc  = 16'(m_fc);
    q.push_back(e);

    if (!rst) begin
      m_waiting = 0;
      m_waited  = 0;
      m_err     = 0;
      m_sc      = 0;
      m_fc      = 0;
    end else begin
      if (!e.v.pcw && m_sc < 65535) m_sc++;
      if (e.v.fl && m_fc < 65535) m_fc++;
      if (m_waiting) begin
        m_waited++;
        if (ack) m_waiting = 0;
        else if (m_waited == TO) begin
          m_err     = 1;
          m_waiting = 0;
        end
      end else if (req && !ack) begin
        m_waiting = 1;
        m_waited  = 0;
      end
    end
  endtask

  task automatic idle(input string name);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, name);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
  endtask

  // Direct spot check against constants; call after a negedge.
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      obs_t a;
      e = q.pop_front();
      a = '{bus.pc_write_o, bus.ifid_write_o, bus.ifid_flush_o, bus.idex_bubble_o,
            bus.pipe_stall_o, bus.err_o, bus.stall_cnt_o, bus.flush_cnt_o};
      total++;
      if (a !== e.v) begin
        bad++;
        $display("FAIL %s: got pcw/ifw/fl/bub/stl/err=%b%b%b%b%b%b sc=%0d fc=%0d, expected %b%b%b%b%b%b sc=%0d fc=%0d",
                 e.name, a.pcw, a.ifw, a.fl, a.bub, a.stl, a.err, a.sc, a.fc,
                 e.v.pcw, e.v.ifw, e.v.fl, e.v.bub, e.v.stl, e.v.err, e.v.sc, e.v.fc);
      end
    end
  end

  initial begin
    rst_n                 = 1'b0;
    bus.ex_memread_i      = 1'b0;
    bus.ex_rd_i           = '0;
    bus.id_rs1_i          = '0;
    bus.id_rs2_i          = '0;
    bus.id_use_rs2_i      = 1'b0;
    bus.id_branch_taken_i = 1'b0;
    bus.mem_req_i         = 1'b0;
    bus.mem_ack_i         = 1'b0;

    // Reset values
    do_reset();
    @(negedge clk);
    chk("rst_flush", int'(bus.ifid_flush_o), 1);
    chk("rst_stall_cnt", int'(bus.stall_cnt_o), 0);
    idle("post_reset");

    // Load-use
    do_reset();
    drive(1, 1, 5, 5, 0, 0, 0, 0, 0, "load_use");
    @(negedge clk);
    chk("load_use_pcw", int'(bus.pc_write_o), 0);
    chk("load_use_bubble", int'(bus.idex_bubble_o), 1);
    idle("load_use_after");
    @(negedge clk);
    chk("load_use_cnt", int'(bus.stall_cnt_o), 1);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, "load_x0");
    @(negedge clk);
    chk("load_x0_pcw", int'(bus.pc_write_o), 1);

    // rs2 gating
    drive(1, 1, 7, 1, 7, 0, 0, 0, 0, "rs2_unused");
    @(negedge clk);
    chk("rs2_unused_pcw", int'(bus.pc_write_o), 1);
    drive(1, 1, 7, 1, 7, 1, 0, 0, 0, "rs2_used");
    @(negedge clk);
    chk("rs2_used_pcw", int'(bus.pc_write_o), 0);

    // Branch vs hazard
    do_reset();
    drive(1, 1, 3, 3, 0, 0, 1, 0, 0, "br_haz");
    @(negedge clk);
    chk("br_haz_flush", int'(bus.ifid_flush_o), 0);
    drive(1, 0, 3, 3, 0, 0, 1, 0, 0, "br_only");
    @(negedge clk);
    chk("br_only_flush", int'(bus.ifid_flush_o), 1);
    idle("br_after");
    @(negedge clk);
    chk("br_flush_cnt", int'(bus.flush_cnt_o), 1);

    // Miss with ack in cycle 3, then zero-wait
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, "miss_c0");
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, "miss_c1");
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, "miss_c2");
    @(negedge clk);
    chk("miss_c2_stall", int'(bus.pipe_stall_o), 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, "miss_c3");
    @(negedge clk);
    chk("miss_ack_stall", int'(bus.pipe_stall_o), 0);
    idle("miss_c4");
    @(negedge clk);
    chk("miss_stall_cnt", int'(bus.stall_cnt_o), 3);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1, "zero_wait");
    @(negedge clk);
    chk("zero_wait_stall", int'(bus.pipe_stall_o), 0);

    // Timeout: one RUN cycle plus TO wait cycles without ack
    do_reset();
    for (int i = 0; i <= int'(TO); i++) drive(1, 0, 0, 0, 0, 0, 0, 1, 0, "timeout");
    idle("timeout_after");
    @(negedge clk);
    chk("timeout_err", int'(bus.err_o), 1);
    chk("timeout_run", int'(bus.pipe_stall_o), 0);
    repeat (3) idle("err_sticky");
    @(negedge clk);
    chk("err_sticky", int'(bus.err_o), 1);
    do_reset();
    @(negedge clk);
    chk("err_cleared", int'(bus.err_o), 0);

    // Reset in the middle of a wait
    idle("pre_mid");
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, "mid_c0");
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, "mid_c1");
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, "mid_reset");
    idle("mid_after");
    @(negedge clk);
    chk("mid_stall", int'(bus.pipe_stall_o), 0);
    chk("mid_stall_cnt", int'(bus.stall_cnt_o), 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) < 3), "random");
    end

    // Saturation of the stall counter
    do_reset();
    for (int i = 0; i < 65540; i++) drive(1, 1, 2, 2, 0, 0, 0, 0, 0, "saturate");
    @(negedge clk);
    chk("stall_cnt_sat", int'(bus.stall_cnt_o), 65535);
    idle("final");

    repeat (4) begin
      if (q.size() != 0) @(negedge clk);
    end
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expected entries left, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
